// File: rtl/systolic_input_skewer_if.sv
// Operand-feeder bus: upstream vector handshake in, skewed array-edge lanes out.
// master drives vectors in; slave is the skewer itself.
interface systolic_input_skewer_if #(
  parameter int DWIDTH = 8,
  parameter int LANES  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DWIDTH-1:0] in_data;
  logic                    in_last;
  logic [LANES*DWIDTH-1:0] out_data;
  logic                    out_valid;
  logic [LANES-1:0]        out_lane_valid;
  logic                    busy;
  logic                    done;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_data, out_valid, out_lane_valid, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_data, out_valid, out_lane_valid, busy, done
  );
endinterface

// File: rtl/systolic_input_skewer.sv
// Buffers a frame of up to DEPTH operand vectors, then replays it with lane i
// delayed by i cycles (zero-padded) to feed a systolic array edge.
module systolic_input_skewer #(
  parameter int DWIDTH = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 4
) (
  input logic                   clk,
  input logic                   reset,
  systolic_input_skewer_if.slave bus
);

  localparam int CW = $clog2(DEPTH + LANES + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           count;
  logic [CW-1:0]           k;
  logic [CW-1:0]           t;
  logic [LANES*DWIDTH-1:0] buffer [DEPTH];

  logic                    accept;
  logic [CW-1:0]           count_next;
  logic [CW-1:0]           last_beat;
  logic [CW-1:0]           idx;
  logic [LANES*DWIDTH-1:0] beat_data;
  logic [LANES-1:0]        beat_lane_valid;

  assign bus.in_ready = (state == LOAD) && (count < CW'(DEPTH));
  assign bus.busy     = (state != LOAD);
  assign accept       = bus.in_valid && bus.in_ready;
  assign count_next   = count + CW'(1);
  assign last_beat    = k + CW'(LANES) - CW'(2);

  // Beat t of the diagonal: lane i shows vector t-i when that vector exists.
  always_comb begin
    beat_data       = '0;
    beat_lane_valid = '0;
    idx             = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = t - CW'(i);
      if ((t >= CW'(i)) && (idx < k)) begin
        beat_data[i*DWIDTH +: DWIDTH] = buffer[idx[AW-1:0]][i*DWIDTH +: DWIDTH];
        beat_lane_valid[i]            = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buffer[count[AW-1:0]] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= LOAD;
      count              <= '0;
      k                  <= '0;
      t                  <= '0;
      bus.out_data       <= '0;
      bus.out_valid      <= 1'b0;
      bus.out_lane_valid <= '0;
      bus.done           <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          bus.out_data       <= '0;
          bus.out_valid      <= 1'b0;
          bus.out_lane_valid <= '0;
          bus.done           <= 1'b0;
          if (accept) begin
            count <= count_next;
            // A full buffer closes the frame even without in_last.
            if (bus.in_last || (count_next == CW'(DEPTH))) begin
              state <= STREAM;
              k     <= count_next;
              t     <= '0;
            end
          end
        end
        STREAM: begin
          bus.out_data       <= beat_data;
          bus.out_lane_valid <= beat_lane_valid;
          bus.out_valid      <= 1'b1;
          t                  <= t + CW'(1);
          if (t == last_beat) begin
            state <= DONE;
          end
        end
        DONE: begin
          bus.out_data       <= '0;
          bus.out_valid      <= 1'b0;
          bus.out_lane_valid <= '0;
          bus.done           <= 1'b1;
          count              <= '0;
          state              <= LOAD;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
